// File: rtl/cfg_commit_sched.sv
// Sensor configuration scheduler: host writes land in a shadow bank that is
// copied to the active bank only at a frame boundary, then one CONFIG_TX run is started.
module cfg_commit_sched #(
   parameter logic [63:0] G_DEFAULT       = 64'h0000_0000_0000_0000,
   parameter int unsigned G_FRAME_TIMEOUT = 2400000,
   parameter int unsigned G_TX_TIMEOUT    = 4800
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_a_i,
   input  logic [2:0]  add_a_i,
   input  logic [7:0]  dat_a_i,
   input  logic        frame_start_i,
   input  logic        re_b_i,
   input  logic [1:0]  add_b_i,
   output logic [15:0] dat_b_o,
   output logic        cfg_start_o,
   input  logic        tx_end_i,
   output logic        busy_o,
   output logic        tx_error_o,
   output logic        mclk_speed_o,
   output logic [1:0]  mclk_mode_o,
   output logic        idle_mode_o,
   output logic [4:0]  rows_delay_o
);

   // state      | meaning
   // IDLE       | nothing pending; leaves as soon as the shadow bank is dirty
   // WAIT_FRAME | waiting for FRAME_START or the frame timeout
   // COMMIT     | one cycle: shadow -> active copy
   // START      | one cycle: launches CONFIG_TX
   // TX         | serving reads until TX_END or the TX timeout
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_FRAME = 3'd1;
   localparam logic [2:0] S_COMMIT     = 3'd2;
   localparam logic [2:0] S_START      = 3'd3;
   localparam logic [2:0] S_TX         = 3'd4;

   localparam logic [22:0] FRAME_TC = 23'(G_FRAME_TIMEOUT - 1);
   localparam logic [22:0] TX_TC    = 23'(G_TX_TIMEOUT - 1);

   logic [2:0]  state_q, state_d;
   logic [22:0] frame_tmr_q, frame_tmr_d;
   logic [22:0] tx_tmr_q, tx_tmr_d;
   logic        dirty_q, dirty_d;
   logic        tx_error_q, tx_error_d;
   logic        cfg_start_q, cfg_start_d;
   logic [63:0] shadow_q;
   logic [63:0] active_q;
   logic [15:0] dat_b_q;
   logic        mclk_speed_q;
   logic [1:0]  mclk_mode_q;
   logic        idle_mode_q;
   logic [4:0]  rows_delay_q;

   always_comb begin
      state_d     = state_q;
      frame_tmr_d = frame_tmr_q;
      tx_tmr_d    = tx_tmr_q;
      dirty_d     = dirty_q;
      tx_error_d  = tx_error_q;
      case (state_q)
         S_IDLE: begin
            if (dirty_q) begin
               state_d     = S_WAIT_FRAME;
               frame_tmr_d = '0;
            end
         end
         S_WAIT_FRAME: begin
            if (frame_start_i || (frame_tmr_q == FRAME_TC)) begin
               state_d = S_COMMIT;
            end else if (frame_tmr_q != '1) begin
               frame_tmr_d = frame_tmr_q + 23'd1;
            end
         end
         S_COMMIT: begin
            dirty_d = 1'b0;
            state_d = S_START;
         end
         S_START: begin
            tx_tmr_d = '0;
            state_d  = S_TX;
         end
         S_TX: begin
            if (tx_end_i) begin
               state_d = S_IDLE;
            end else if (tx_tmr_q == TX_TC) begin
               tx_error_d = 1'b1;
               dirty_d    = 1'b1;
               state_d    = S_IDLE;
            end else if (tx_tmr_q != '1) begin
               tx_tmr_d = tx_tmr_q + 23'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A write in the commit cycle is not part of that commit, so it must keep DIRTY set.
      if (we_a_i) begin
         dirty_d = 1'b1;
      end
   end

   // Registered so START reaches CONFIG_TX together with the updated field outputs.
   assign cfg_start_d = (state_q == S_START);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         frame_tmr_q <= '0;
         tx_tmr_q    <= '0;
         dirty_q     <= 1'b0;
         tx_error_q  <= 1'b0;
         cfg_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_tmr_q <= frame_tmr_d;
         tx_tmr_q    <= tx_tmr_d;
         dirty_q     <= dirty_d;
         tx_error_q  <= tx_error_d;
         cfg_start_q <= cfg_start_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= G_DEFAULT;
      end else if (we_a_i) begin
         shadow_q[{add_a_i, 3'b000} +: 8] <= dat_a_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= G_DEFAULT;
      end else if (state_q == S_COMMIT) begin
         active_q <= shadow_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dat_b_q      <= G_DEFAULT[15:0];
         mclk_speed_q <= G_DEFAULT[0];
         mclk_mode_q  <= G_DEFAULT[2:1];
         idle_mode_q  <= G_DEFAULT[3];
         rows_delay_q <= G_DEFAULT[12:8];
      end else begin
         if (re_b_i) begin
            dat_b_q <= active_q[{add_b_i, 4'b0000} +: 16];
         end
         mclk_speed_q <= active_q[0];
         mclk_mode_q  <= active_q[2:1];
         idle_mode_q  <= active_q[3];
         rows_delay_q <= active_q[12:8];
      end
   end

   assign dat_b_o      = dat_b_q;
   assign cfg_start_o  = cfg_start_q;
   assign busy_o       = (state_q != S_IDLE);
   assign tx_error_o   = tx_error_q;
   assign mclk_speed_o = mclk_speed_q;
   assign mclk_mode_o  = mclk_mode_q;
   assign idle_mode_o  = idle_mode_q;
   assign rows_delay_o = rows_delay_q;

endmodule
